// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-fetch path: FSM states, default
// resolution and the colour-bar palette used by the built-in test pattern.
package vga_pkg;

    localparam int unsigned DEFAULT_H_RES = 640;
    localparam int unsigned DEFAULT_V_RES = 480;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StData = 2'd2,
        StGap  = 2'd3
    } fetch_state_e;

    // Entry 0 is the leftmost bar. Pixels are B[23:16] G[15:8] R[7:0].
    localparam logic [7:0][23:0] BAR_BGR = {
        24'h000000,  // 7 black
        24'hFF0000,  // 6 blue
        24'h0000FF,  // 5 red
        24'hFF00FF,  // 4 magenta
        24'h00FF00,  // 3 green
        24'hFFFF00,  // 2 cyan
        24'h00FFFF,  // 1 yellow
        24'hFFFFFF   // 0 white
    };

endpackage

// File: rtl/pixel_addr_counter.sv
// Burst-granular pixel counter for the frame fetcher. Advances by one burst
// on each completed burst, wraps at the end of the frame, pulses frame_done
// on the cycle after the wrap and forms the SDRAM burst start address.
module pixel_addr_counter
    import vga_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned H_RES     = DEFAULT_H_RES,
    parameter int unsigned V_RES     = DEFAULT_V_RES,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned ADDR_W    = 22
) (
    input  logic              clk75,
    input  logic              rst,
    input  logic              advance,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              frame_done
);

    localparam int unsigned FRAME_PIX = H_RES * V_RES;

    logic [18:0] pix_q;
    logic [19:0] pix_sum;
    logic        wrap;
    logic        frame_done_q;

    // One extra bit so the end-of-frame sum is representable before wrapping.
    always_comb begin
        pix_sum = {1'b0, pix_q} + 20'(BURST_LEN);
        wrap    = (pix_sum == 20'(FRAME_PIX));
    end

    // Pixel counter and frame-done pulse register.
    always_ff @(posedge clk75 or posedge rst) begin
        if (rst) begin
            pix_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= advance && wrap;
            if (advance) begin
                pix_q <= wrap ? '0 : pix_sum[18:0];
            end
        end
    end

    // Burst start address: base plus zero-extended pixel index.
    always_comb begin
        rd_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(pix_q);
        frame_done = frame_done_q;
    end

endmodule

// File: rtl/sdram_frame_fetcher.sv
// SDRAM frame fetcher: walks a linear frame buffer in fixed-length read
// bursts and forwards the returned pixels to the VGA pixel FIFO, issuing a
// burst only when the FIFO has room for it plus some slack.
// Build option: define FETCH_TEST_PATTERN_EN to replace SDRAM data with
// internally generated vertical colour bars (rd_req then stays low).
module sdram_frame_fetcher
    import vga_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned H_RES     = DEFAULT_H_RES,
    parameter int unsigned V_RES     = DEFAULT_V_RES,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned SLACK     = 4,
    parameter int unsigned ADDR_W    = 22
) (
    input  logic              clk75,
    input  logic              rst,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [31:0]       rd_data,
    input  logic              rd_valid,
    input  logic [6:0]        freeslots,
    output logic [23:0]       data_bgr,
    output logic              wr_en,
    output logic              frame_done
);

    // 8-bit compare so BURST_LEN + SLACK up to 64 cannot overflow.
    localparam logic [7:0] THRESHOLD = 8'(BURST_LEN + SLACK);
    localparam logic [5:0] LAST_BEAT = 6'(BURST_LEN - 1);

`ifdef FETCH_TEST_PATTERN_EN
    localparam bit PATTERN_MODE = 1'b1;
`else
    localparam bit PATTERN_MODE = 1'b0;
`endif

    fetch_state_e state_q, state_d;
    logic [5:0]   beat_q, beat_d;
    logic         wr_en_q, wr_en_d;
    logic [23:0]  data_q, data_d;
    logic         advance;
    logic         have_room;
    logic         beat_valid;
    logic [23:0]  beat_pixel;

`ifdef FETCH_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_RES / 8;

    logic [18:0] col_q;
    logic [2:0]  bar_q;
    logic        unused_sdram;

    assign unused_sdram = rd_ack ^ rd_valid ^ (^rd_data);

    // Generated beats: one per DATA cycle, colour taken from the current bar.
    always_comb begin
        beat_valid = 1'b1;
        beat_pixel = BAR_BGR[bar_q];
    end

    // Bar position tracker; bars tile each line exactly, so it realigns
    // at every line and frame boundary by itself.
    always_ff @(posedge clk75 or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            bar_q <= '0;
        end else if (state_q == StData) begin
            if (col_q == 19'(BAR_W - 1)) begin
                col_q <= '0;
                bar_q <= bar_q + 3'd1;
            end else begin
                col_q <= col_q + 19'd1;
            end
        end
    end
`else
    logic unused_rd_hi;

    assign unused_rd_hi = ^rd_data[31:24];

    // SDRAM beats pass straight through.
    always_comb begin
        beat_valid = rd_valid;
        beat_pixel = rd_data[23:0];
    end
`endif

    // State, beat counter and FIFO output registers.
    always_ff @(posedge clk75 or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic; a burst ends after BURST_LEN accepted beats.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wr_en_d   = 1'b0;
        data_d    = data_q;
        advance   = 1'b0;
        have_room = ({1'b0, freeslots} >= THRESHOLD);
        unique case (state_q)
            StIdle: begin
                if (have_room) begin
                    beat_d  = '0;
                    state_d = PATTERN_MODE ? StData : StReq;
                end
            end
            StReq: begin
                if (rd_ack) begin
                    beat_d  = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (beat_valid) begin
                    wr_en_d = 1'b1;
                    data_d  = beat_pixel;
                    beat_d  = beat_q + 6'd1;
                    if (beat_q == LAST_BEAT) begin
                        advance = 1'b1;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    pixel_addr_counter #(
        .BASE_ADDR (BASE_ADDR),
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .BURST_LEN (BURST_LEN),
        .ADDR_W    (ADDR_W)
    ) u_pixel_addr_counter (
        .clk75      (clk75),
        .rst        (rst),
        .advance    (advance),
        .rd_addr    (rd_addr),
        .frame_done (frame_done)
    );

    // Output drive; the request is a pure decode of the REQ state.
    always_comb begin
        rd_req   = (state_q == StReq) && !PATTERN_MODE;
        wr_en    = wr_en_q;
        data_bgr = data_q;
    end

endmodule

// File: tb/tb_sdram_frame_fetcher.sv
// Directed self-checking bench for sdram_frame_fetcher (SDRAM fetch build).
// Small frame (8x2, burst 8) so wrap and frame_done occur every 2 bursts.
module tb_sdram_frame_fetcher;

    localparam int unsigned BASE = 32'h100;

    logic        clk75 = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [21:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [6:0]  freeslots;
    logic [23:0] data_bgr;
    logic        wr_en;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    sdram_frame_fetcher #(
        .BASE_ADDR (BASE),
        .H_RES     (8),
        .V_RES     (2),
        .BURST_LEN (8),
        .SLACK     (4),
        .ADDR_W    (22)
    ) dut (
        .clk75      (clk75),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .freeslots  (freeslots),
        .data_bgr   (data_bgr),
        .wr_en      (wr_en),
        .frame_done (frame_done)
    );

    always #5 clk75 = ~clk75;

    task automatic tick();
        @(posedge clk75);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        rd_ack    = 1'b0;
        rd_data   = '0;
        rd_valid  = 1'b0;
        freeslots = 7'd11;

        // Reset state
        repeat (3) tick();
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_rd_addr", 32'(rd_addr), BASE);
        check("rst_data_bgr", 32'(data_bgr), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        rst = 1'b0;
        repeat (3) tick();
        check("below_thresh_11", 32'(rd_req), 0);

        // Burst 1: ack two cycles after request, back-to-back beats
        freeslots = 7'd64;
        tick();
        check("b1_req", 32'(rd_req), 1);
        check("b1_addr", 32'(rd_addr), BASE);
        tick();
        check("b1_req_held", 32'(rd_req), 1);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("b1_req_drop", 32'(rd_req), 0);
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1;
            rd_data  = 32'h00AABBCC + i;
            tick();
            check("b1_wr_en", 32'(wr_en), 1);
            check("b1_data", 32'(data_bgr), 32'h00AABBCC + i);
        end
        rd_valid = 1'b0;
        check("b1_no_done", 32'(frame_done), 0);
        tick();
        check("b1_idle_wr", 32'(wr_en), 0);
        check("b1_idle_req", 32'(rd_req), 0);
        tick();
        check("b2_req_turnaround", 32'(rd_req), 1);
        check("b2_addr", 32'(rd_addr), BASE + 8);

        // Burst 2: ack immediately, 3-cycle hole mid-burst, ends the frame
        freeslots = 7'd0;
        rd_ack    = 1'b1;
        tick();
        rd_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1;
            rd_data  = 32'hFF112200 + i;
            tick();
            check("b2_wr_en", 32'(wr_en), 1);
            check("b2_data", 32'(data_bgr), 32'h00112200 + i);
            rd_valid = 1'b0;
            if (i == 3) begin
                repeat (3) begin
                    tick();
                    check("b2_hole_wr", 32'(wr_en), 0);
                end
            end
        end
        check("b2_frame_done", 32'(frame_done), 1);
        tick();
        check("b2_done_pulse", 32'(frame_done), 0);
        check("b2_wrap_addr", 32'(rd_addr), BASE);

        // Stray beat and stray ack in IDLE are ignored
        rd_valid = 1'b1;
        rd_data  = 32'h00DEAD00;
        tick();
        rd_valid = 1'b0;
        check("stray_valid_wr", 32'(wr_en), 0);
        rd_ack = 1'b1;
        tick();
        rd_ack   = 1'b0;
        rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        check("stray_ack_wr", 32'(wr_en), 0);
        check("stray_data_held", 32'(data_bgr), 32'h00112207);
        check("stray_no_req", 32'(rd_req), 0);

        // Burst 3: threshold boundary 11 -> 12
        freeslots = 7'd11;
        tick();
        check("thresh_11", 32'(rd_req), 0);
        freeslots = 7'd12;
        tick();
        check("thresh_12", 32'(rd_req), 1);
        check("b3_addr", 32'(rd_addr), BASE);
        freeslots = 7'd0;
        rd_ack    = 1'b1;
        tick();
        rd_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1;
            rd_data  = 32'h00000010 + i;
            tick();
            check("b3_data", 32'(data_bgr), 32'h00000010 + i);
        end
        rd_valid = 1'b0;
        check("b3_no_done", 32'(frame_done), 0);
        tick();
        check("b3_next_addr", 32'(rd_addr), BASE + 8);

        // Burst 4: async reset after beat 4
        freeslots = 7'd64;
        tick();
        check("b4_req", 32'(rd_req), 1);
        rd_ack = 1'b1;
        tick();
        rd_ack    = 1'b0;
        freeslots = 7'd0;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1;
            rd_data  = 32'h00C0FFE0 + i;
            tick();
            check("b4_data", 32'(data_bgr), 32'h00C0FFE0 + i);
        end
        check("b4_wr_before_rst", 32'(wr_en), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_wr_en", 32'(wr_en), 0);
        check("arst_data", 32'(data_bgr), 0);
        check("arst_addr", 32'(rd_addr), BASE);
        check("arst_req", 32'(rd_req), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_drop", 32'(wr_en), 0);
        rd_valid = 1'b0;
        check("post_rst_idle", 32'(rd_req), 0);
        freeslots = 7'd64;
        tick();
        check("post_rst_req", 32'(rd_req), 1);
        check("post_rst_addr", 32'(rd_addr), BASE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_frame_fetcher.md
# sdram_frame_fetcher

- Upstream feeder for the VGA output stage. Runs on `clk75`.
- Walks a linear frame buffer in SDRAM and issues fixed-length read bursts to the SDRAM controller.
- Forwards the returned pixels to the VGA pixel FIFO as `data_bgr`/`wr_en`.
- Issues a new burst only when the FIFO's reported `freeslots` can absorb it.

## Interface

Parameters:
- `BASE_ADDR`, 0: SDRAM word address of pixel (0,0).
- `H_RES`, 640: pixels per line.
- `V_RES`, 480: lines per frame.
- `BURST_LEN`, 8: words per read burst. Must divide `H_RES*V_RES`; must be ≤ 32.
- `SLACK`, 4: extra free slots required beyond `BURST_LEN`. Covers FIFO `wrusedw` latency.
- `ADDR_W`, 22: SDRAM address width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk75`  in  1  system/SDRAM clock.
  - `rst`  in  1  asynchronous active-high reset.
- SDRAM read side:
  - `rd_req`  out  1  burst request, held until acknowledged.
  - `rd_addr`  out  ADDR_W  burst start word address.
  - `rd_ack`  in  1  controller accepted the request (1-cycle pulse).
  - `rd_data`  in  32  read word; pixel in [23:0] as B[23:16] G[15:8] R[7:0].
  - `rd_valid`  in  1  `rd_data` valid this cycle.
- VGA FIFO side:
  - `freeslots`  in  7  free FIFO entries (0..64).
  - `data_bgr`  out  24  pixel to the FIFO.
  - `wr_en`  out  1  FIFO write strobe.
- Status:
  - `frame_done`  out  1  1-cycle pulse after the last pixel of a frame is written.

## Operation

- Pixel counter `pix` (19 bits, range 0..`H_RES*V_RES-1`) gives the start of the next burst. `rd_addr = BASE_ADDR + pix`, zero-extended to `ADDR_W`.
- FSM states:
  - IDLE: go to REQ when `freeslots >= BURST_LEN + SLACK`.
  - REQ: `rd_req=1`, `rd_addr` stable. On `rd_ack`, go to DATA and clear the beat counter.
  - DATA: each `rd_valid` forwards one pixel and increments the beat counter. When the beat count reaches `BURST_LEN`, go to GAP.
  - GAP: one dead cycle, then IDLE. This lets `freeslots` reflect the burst's writes.
- On DATA exit, `pix += BURST_LEN`.
  - If the result equals `H_RES*V_RES`, `pix` wraps to 0 and `frame_done` pulses in the GAP cycle.
- `rd_valid` outside DATA is ignored: no write, no count.
- `rd_ack` outside REQ is ignored.
- `rd_valid` gaps inside a burst are legal; the FSM waits indefinitely.
- Threshold arithmetic: compare in 8 bits so `BURST_LEN+SLACK` up to 64 cannot overflow. `freeslots=64` with default parameters passes.

## Timing

- Reset values: `rd_req=0`, `rd_addr=BASE_ADDR`, `data_bgr=0`, `wr_en=0`, `frame_done=0`, FSM=IDLE, `pix=0`.
- `data_bgr`/`wr_en` are registered: `rd_valid` at cycle n gives `wr_en=1` at n+1, with `data_bgr=rd_data[23:0]` captured at n.
- Request latency: `freeslots` crossing the threshold at cycle n gives `rd_req=1` at n+1.
- Minimum turnaround, last data beat to next `rd_req`: 3 cycles (DATA→GAP→IDLE→REQ).
- `rd_ack` in the same cycle `rd_req` first rises is accepted; DATA begins the next cycle.
- Reset mid-burst: all state returns to reset values immediately. Remaining `rd_valid` beats from the aborted burst arrive in IDLE and are dropped. The controller must also be reset.
- At most one burst is outstanding; no pipelined requests.

## Configuration

- `FETCH_TEST_PATTERN_EN`
  - Defined: SDRAM port unused (`rd_req` held 0). The FSM skips REQ: IDLE→DATA, with one internally generated beat per cycle.
    - Pixels are eight vertical colour bars of `H_RES/8` px: white, yellow, cyan, green, magenta, red, blue, black.
    - Data is in BGR order; `pix` and `frame_done` behave identically.
  - Undefined: normal SDRAM fetch.

## Structure

- Shared package `vga_pkg`:
  - FSM state enum (IDLE, REQ, DATA, GAP).
  - Default `H_RES`/`V_RES`.
  - Colour-bar BGR constant array.
- One natural sub-module, `pixel_addr_counter`:
  - burst-granular `pix` counter with wrap;
  - `frame_done` generation;
  - `rd_addr` adder.
- FSM and output registers stay in the top module.

## Test plan

- Reset: hold `rst`, then release → all outputs at reset values; `rd_req=0` while `freeslots=11` (below the default threshold of 12).
- `freeslots=64`, `rd_ack` 2 cycles after `rd_req`, 8 `rd_valid` beats with `rd_data=32'h00AABBCC+i` → 8 `wr_en` pulses each 1 cycle after `rd_valid`, `data_bgr=24'hAABBCC+i`; next `rd_addr=BASE_ADDR+8`.
- `rd_valid` with 3-cycle holes mid-burst, plus a stray `rd_valid` in IDLE → exactly 8 writes, stray beat dropped.
- `H_RES=8`, `V_RES=2`, `BURST_LEN=8`, `freeslots=64` → `rd_addr` sequence 0, 8, 0, 8…; `frame_done` pulses once per 2 bursts, 1 cycle after the 16th pixel's last beat.
- Async `rst` asserted after beat 4 of a burst → outputs reset same cycle; after release, first `rd_addr=BASE_ADDR`.
- With `FETCH_TEST_PATTERN_EN` and `H_RES=640`: `rd_req` stays 0; `data_bgr` at pix 0 = `24'hFFFFFF`, at pix 80 = `24'h00FFFF` (yellow, BGR); `frame_done` after 307200 writes.
